// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with shadow/active digit banks and frame-aligned commit.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
module seg_scan_ctrl #(
   parameter int NDIG      = 8,
   parameter int SCAN_DIV  = 50000,
   parameter int GAP       = 1000,
   parameter int BLINK_DIV = 64,
   localparam int AW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic            wr_commit,
   input  logic [AW-1:0]   wr_addr,
   input  logic [3:0]      wr_data,
   input  logic            wr_blank,
`ifdef SEG_BLINK_EN
   input  logic            wr_blink,
`endif
   output logic [6:0]      seg,
   output logic [NDIG-1:0] an,
   output logic            busy,
   output logic            frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {S_GAP, S_SHOW} state_t;
   // With GAP = 0 the first slot must already be showing out of reset.
   localparam state_t S_RST = (GAP > 0) ? S_GAP : S_SHOW;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [AW-1:0]         r_idx;
   logic [NDIG-1:0][3:0]  r_sh_dat, r_act_dat;
   logic [NDIG-1:0]       r_sh_blk, r_act_blk;
   logic                  r_busy;
   logic [NDIG-1:0]       r_an;
   logic [6:0]            r_seg;
   logic                  r_frame_done;

   logic                  w_last, w_boundary, w_acc, w_addr_ok, w_dark;
   logic [CW-1:0]         w_cnt_nxt;
   logic [AW-1:0]         w_idx_nxt;
   logic [NDIG-1:0]       w_an_on;

   function automatic logic [6:0] bcd7seg(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   assign w_last     = (r_cnt == CW'(SCAN_DIV - 1));
   assign w_boundary = w_last && (r_idx == AW'(NDIG - 1));
   assign w_cnt_nxt  = w_last ? '0 : r_cnt + 1'b1;
   assign w_idx_nxt  = (r_idx == AW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
   assign w_acc      = wr_valid && !r_busy;

   if (NDIG == (1 << AW)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
   end else begin : g_addr_part
      assign w_addr_ok = (int'(wr_addr) < NDIG);
   end

   always_comb begin
      w_an_on        = '1;
      w_an_on[r_idx] = 1'b0;
   end

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   logic [NDIG-1:0] r_sh_bnk, r_act_bnk;
   logic [BW-1:0]   r_bfrm;
   logic            r_phase;

   assign w_dark = r_act_blk[r_idx] | (r_act_bnk[r_idx] & r_phase);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_bnk  <= '0;
         r_act_bnk <= '0;
         r_bfrm    <= '0;
         r_phase   <= 1'b0;
      end else begin
         if (w_acc && !wr_commit && w_addr_ok)
            r_sh_bnk[wr_addr] <= wr_blink;
         if (w_boundary && r_busy)
            r_act_bnk <= r_sh_bnk;
         if (w_boundary) begin
            if (r_bfrm == BW'(BLINK_DIV - 1)) begin
               r_bfrm  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_bfrm  <= r_bfrm + 1'b1;
            end
         end
      end
   end
`else
   assign w_dark = r_act_blk[r_idx];
`endif

   // Slot FSM; outputs are registered from the pre-edge state, giving one cycle of lag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_RST;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_frame_done <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_state      <= (w_cnt_nxt < CW'(GAP)) ? S_GAP : S_SHOW;
         r_frame_done <= w_boundary;
         if (w_last)
            r_idx <= w_idx_nxt;
         if (r_state == S_SHOW && !w_dark) begin
            r_an  <= w_an_on;
            r_seg <= bcd7seg(r_act_dat[r_idx]);
         end else begin
            r_an  <= '1;
            r_seg <= 7'h7F;
         end
      end
   end

   // Banks swap only on a frame boundary with a commit pending; busy blocks further requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_dat  <= '0;
         r_sh_blk  <= '1;
         r_act_dat <= '0;
         r_act_blk <= '1;
         r_busy    <= 1'b0;
      end else begin
         if (w_acc && !wr_commit && w_addr_ok) begin
            r_sh_dat[wr_addr] <= wr_data;
            r_sh_blk[wr_addr] <= wr_blank;
         end
         if (w_boundary && r_busy) begin
            r_act_dat <= r_sh_dat;
            r_act_blk <= r_sh_blk;
         end
         if (w_acc && wr_commit)
            r_busy <= 1'b1;
         else if (w_boundary)
            r_busy <= 1'b0;
      end
   end

   assign wr_ready   = ~r_busy;
   assign busy       = r_busy;
   assign seg        = r_seg;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, SCAN_DIV=8, GAP=2 (blink steps need SEG_BLINK_EN).
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, wr_valid, wr_commit, wr_blank;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
`ifdef SEG_BLINK_EN
   logic       wr_blink;
`endif
   logic       wr_ready, busy, frame_done;
   logic [6:0] seg;
   logic [3:0] an;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   seg_scan_ctrl #(.NDIG(4), .SCAN_DIV(8), .GAP(2), .BLINK_DIV(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_commit  (wr_commit),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_blank   (wr_blank),
`ifdef SEG_BLINK_EN
      .wr_blink   (wr_blink),
`endif
      .seg        (seg),
      .an         (an),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   // Checks frame-relative edges k0..k1 (k = 1..32); blk bit i = 1 means digit i expected dark.
   task automatic frame_chk(input int k0, input int k1, input logic [3:0] blk,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input bit do_wr, input logic [1:0] wa, input logic [3:0] wd,
                            input bit commit_last, input bit hold);
      logic [6:0] sv [4];
      logic [3:0] ea;
      logic [6:0] es;
      int c, i;
      sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
      for (int k = k0; k <= k1; k++) begin
         if (k == k0 && do_wr) begin
            wr_valid = 1'b1; wr_commit = 1'b0; wr_addr = wa; wr_data = wd; wr_blank = 1'b0;
         end else if (k == k0 && hold) begin
            wr_valid = 1'b1; wr_commit = 1'b1;
         end
         if (k == 32 && commit_last) begin
            wr_valid = 1'b1; wr_commit = 1'b1;
         end
         tick();
         if (!hold) wr_valid = 1'b0;
         c  = (k - 1) % 8;
         i  = (k - 1) / 8;
         ea = 4'hF;
         es = 7'h7F;
         if (c >= 2 && !blk[i]) begin
            ea[i] = 1'b0;
            es    = sv[i];
         end
         chk("an", 16'(an), 16'(ea));
         chk("seg", 16'(seg), 16'(es));
         chk("frame_done", 16'(frame_done), 16'(k == 32));
         if (hold && k < 32) begin
            chk("hold_busy", 16'(busy), 16'd1);
            chk("hold_ready", 16'(wr_ready), 16'd0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0; wr_addr = '0; wr_data = '0; wr_blank = 1'b1;
`ifdef SEG_BLINK_EN
      wr_blink = 1'b0;
`endif
      #8;
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_fd", 16'(frame_done), 16'd0);
      chk("rst_ready", 16'(wr_ready), 16'd1);
      #4 rst_n = 1'b1;

      // Idle: everything blank, frame_done every 32 edges.
      for (int e = 1; e <= 100; e++) begin
         tick();
         chk("idle_an", 16'(an), 16'hF);
         chk("idle_seg", 16'(seg), 16'h7F);
         chk("idle_fd", 16'(frame_done), 16'(e % 32 == 0));
         chk("idle_busy", 16'(busy), 16'd0);
      end

      // Shadow writes digit0 = 0, digit1 = 3, then commit.
      wr_valid = 1'b1; wr_commit = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; wr_blank = 1'b0;
      tick();
      wr_addr = 2'd1; wr_data = 4'd3;
      tick();
      chk("wr_ready", 16'(wr_ready), 16'd1);
      wr_commit = 1'b1;
      tick();
      wr_valid = 1'b0;
      chk("cm_busy", 16'(busy), 16'd1);
      chk("cm_ready", 16'(wr_ready), 16'd0);
      repeat (24) begin
         tick();
         chk("pend_busy", 16'(busy), 16'd1);
         chk("pend_an", 16'(an), 16'hF);
      end
      tick();
      chk("n128", 16'(n), 16'd128);
      chk("bnd_busy", 16'(busy), 16'd0);
      chk("bnd_ready", 16'(wr_ready), 16'd1);
      chk("bnd_fd", 16'(frame_done), 16'd1);

      // Frame A: new digits visible; write digit2 = 5 and commit on the boundary cycle.
      frame_chk(1, 32, 4'b1100, 7'h40, 7'h30, 7'h7F, 7'h7F, 1'b1, 2'd2, 4'd5, 1'b1, 1'b0);
      chk("bcm_busy", 16'(busy), 16'd1);
      chk("bcm_ready", 16'(wr_ready), 16'd0);

      // Frame B: unchanged display; second commit held while busy.
      frame_chk(1, 32, 4'b1100, 7'h40, 7'h30, 7'h7F, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
      chk("b_end_busy", 16'(busy), 16'd0);
      chk("b_end_ready", 16'(wr_ready), 16'd1);
      tick();
      wr_valid = 1'b0;
      chk("held_acc_busy", 16'(busy), 16'd1);
      chk("held_acc_ready", 16'(wr_ready), 16'd0);
      chk("c1_an", 16'(an), 16'hF);

      // Frame C: digit2 now visible; reset mid-SHOW with a commit pending.
      frame_chk(2, 8, 4'b1000, 7'h40, 7'h30, 7'h12, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("arst_an", 16'(an), 16'hF);
      chk("arst_seg", 16'(seg), 16'h7F);
      chk("arst_busy", 16'(busy), 16'd0);
      chk("arst_ready", 16'(wr_ready), 16'd1);
      chk("arst_fd", 16'(frame_done), 16'd0);
      #2 rst_n = 1'b1;
      n = 0;

      // Commit right away: shadow blanks must have returned to 1, so display stays dark.
      wr_valid = 1'b1; wr_commit = 1'b1;
      tick();
      wr_valid = 1'b0;
      chk("r_cm_busy", 16'(busy), 16'd1);
      frame_chk(2, 32, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
      chk("r_bnd_busy", 16'(busy), 16'd0);
      frame_chk(1, 32, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

`ifdef SEG_BLINK_EN
      // Frame 2: write blinking digit0 = 0, commit on boundary -> active from frame 4.
      wr_blink = 1'b1;
      frame_chk(1, 32, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
      wr_blink = 1'b0;
      for (int f = 3; f <= 7; f++) begin
         if (f >= 4 && ((f / 2) % 2 == 0))
            frame_chk(1, 32, 4'b1110, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
         else
            frame_chk(1, 32, 4'b1111, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
